// File: rtl/tx_uart.sv
// UART transmitter: start bit, WL data bits LSB first, even-parity bit, one stop bit.
// Words are accepted through a valid/ready handshake; the serial line is driven from a flop.
module tx_uart #(
  parameter int WL        = 8,
  parameter int BAUD_RATE = 9600,
  parameter int CLK_FREQ  = 100000000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          tx_valid,
  input  logic [WL-1:0] din,
  output logic          tx_ready,
  output logic          uart_tx,
  output logic          tx_done
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam int BIT_W      = $clog2(WL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_baud;
  logic [BIT_W-1:0] r_bit;
  logic [WL-1:0]    r_shift;
  logic             r_parity;
  logic             r_tx;
  logic             r_ready;
  logic             r_done;

  logic w_bit_end;
  logic w_accept;

  assign w_bit_end = (r_baud == CNT_LAST);
  assign w_accept  = tx_valid && r_ready;

  assign tx_ready = r_ready;
  assign uart_tx  = r_tx;
  assign tx_done  = r_done;

  // Frame data path: loaded on acceptance, bit 0 is consumed each time a data bit is launched.
  always_ff @(posedge CLK) begin
    if (r_state == S_IDLE && w_accept) begin
      r_shift  <= din;
      r_parity <= ^din;
    end else if (w_bit_end && (r_state == S_START || r_state == S_DATA)) begin
      r_shift  <= r_shift >> 1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) begin
        r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          if (w_accept) begin
            r_tx    <= 1'b0;
            r_ready <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit == BIT_LAST) begin
              r_bit   <= '0;
              r_tx    <= r_parity;
              r_state <= S_PARITY;
            end else begin
              r_bit <= r_bit + 1'b1;
              r_tx  <= r_shift[0];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_uart.sv
// Bench for tx_uart with WL=8, BIT_CYCLES=16: every frame cycle is compared against a
// bit list built from the word (start, data LSB first, even parity, stop).
module tb_tx_uart;

  localparam int WL    = 8;
  localparam int BC    = 16;
  localparam int NBITS = WL + 3;
  localparam int FRAME = NBITS * BC;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          tx_valid = 1'b0;
  logic [WL-1:0] din = '0;
  logic          tx_ready;
  logic          uart_tx;
  logic          tx_done;

  int errors = 0;
  int checks = 0;
  int nprint = 0;

  tx_uart #(.WL(WL), .BAUD_RATE(1), .CLK_FREQ(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .tx_valid (tx_valid),
    .din      (din),
    .tx_ready (tx_ready),
    .uart_tx  (uart_tx),
    .tx_done  (tx_done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic report(input string name, input int c, input logic act, input logic exp);
    errors++;
    if (nprint < 40) begin
      nprint++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, c, act, exp);
    end
  endtask

  // Expected line level for frame bit n of word w.
  function automatic logic model_bit(input logic [WL-1:0] w, input int n);
    int ones;
    ones = 0;
    for (int i = 0; i < WL; i++) ones += (w >> i) & 1;
    if (n == 0) return 1'b0;
    if (n <= WL) return logic'((w >> (n - 1)) & 1);
    if (n == WL + 1) return logic'(ones % 2);
    return 1'b1;
  endfunction

  // Called at the negedge before the acceptance edge; returns at negedge of frame cycle 1.
  task automatic start_word(input logic [WL-1:0] w);
    din      = w;
    tx_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    tx_valid = 1'b0;
  endtask

  // Entered at negedge of frame cycle 1. abort_at>0 resets the DUT in that cycle.
  // chain=1 offers nxt in the tx_done cycle and returns at cycle 1 of the next frame.
  task automatic check_frame(input logic [WL-1:0] w, input bit busy, input int abort_at,
                             input bit chain, input logic [WL-1:0] nxt);
    for (int c = 1; c <= FRAME; c++) begin
      checks++;
      if (uart_tx !== model_bit(w, (c - 1) / BC)) report("line", c, uart_tx, model_bit(w, (c - 1) / BC));
      checks++;
      if (tx_ready !== 1'b0) report("ready_busy", c, tx_ready, 1'b0);
      checks++;
      if (tx_done !== 1'b0) report("done_early", c, tx_done, 1'b0);
      if (c == abort_at) begin
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if (uart_tx !== 1'b1) report("rst_line", c + 1, uart_tx, 1'b1);
        checks++;
        if (tx_ready !== 1'b1) report("rst_ready", c + 1, tx_ready, 1'b1);
        checks++;
        if (tx_done !== 1'b0) report("rst_done", c + 1, tx_done, 1'b0);
        return;
      end
      if (busy && c == 40) begin
        din      = ~w;
        tx_valid = 1'b1;
      end
      if (busy && c == 41) begin
        din      = $urandom;
        tx_valid = 1'b0;
      end
      @(negedge CLK);
    end
    checks++;
    if (tx_done !== 1'b1) report("done_pulse", FRAME + 1, tx_done, 1'b1);
    checks++;
    if (tx_ready !== 1'b1) report("ready_end", FRAME + 1, tx_ready, 1'b1);
    checks++;
    if (uart_tx !== 1'b1) report("idle_line", FRAME + 1, uart_tx, 1'b1);
    if (chain) begin
      start_word(nxt);
    end else begin
      @(negedge CLK);
      checks++;
      if (tx_done !== 1'b0) report("done_width", FRAME + 2, tx_done, 1'b0);
      checks++;
      if (uart_tx !== 1'b1) report("idle_after", FRAME + 2, uart_tx, 1'b1);
    end
  endtask

  task automatic test_reset();
    RST      = 1'b1;
    tx_valid = 1'b1;
    din      = 8'hF0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (uart_tx !== 1'b1) report("reset_line", 0, uart_tx, 1'b1);
    checks++;
    if (tx_ready !== 1'b1) report("reset_ready", 0, tx_ready, 1'b1);
    checks++;
    if (tx_done !== 1'b0) report("reset_done", 0, tx_done, 1'b0);
    tx_valid = 1'b0;
    RST      = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (uart_tx !== 1'b1) report("idle_line_no_valid", 0, uart_tx, 1'b1);
  endtask

  task automatic test_single();
    start_word(8'hA5);
    check_frame(8'hA5, 1'b0, 0, 1'b0, '0);
  endtask

  task automatic test_parity();
    logic [WL-1:0] w;
    start_word(8'h07);
    check_frame(8'h07, 1'b0, 0, 1'b0, '0);
    start_word(8'h00);
    check_frame(8'h00, 1'b0, 0, 1'b0, '0);
    start_word(8'hFF);
    check_frame(8'hFF, 1'b0, 0, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      w = WL'($urandom);
      start_word(w);
      check_frame(w, 1'b0, 0, 1'b0, '0);
    end
  endtask

  task automatic test_back_to_back();
    start_word(8'h3C);
    check_frame(8'h3C, 1'b0, 0, 1'b1, 8'hC3);
    check_frame(8'hC3, 1'b0, 0, 1'b0, '0);
  endtask

  task automatic test_busy_ignore();
    start_word(8'h55);
    check_frame(8'h55, 1'b1, 0, 1'b0, '0);
    repeat (20) begin
      @(negedge CLK);
      checks++;
      if (uart_tx !== 1'b1) report("no_second_frame", 0, uart_tx, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    start_word(8'h00);
    check_frame(8'h00, 1'b0, 90, 1'b0, '0);
    repeat (5) begin
      @(negedge CLK);
      checks++;
      if (tx_done !== 1'b0) report("no_done_after_rst", 0, tx_done, 1'b0);
      checks++;
      if (uart_tx !== 1'b1) report("idle_after_rst", 0, uart_tx, 1'b1);
    end
    start_word(8'h81);
    check_frame(8'h81, 1'b0, 0, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_uart.md
# tx_uart

UART transmitter that serialises parallel words into 8N1-style frames extended with an even-parity bit: start bit, WL data bits LSB first, parity bit, one stop bit. It sits directly upstream of the lab's UART receiver on the serial line and drives `uart_tx`. Words arrive from on-chip logic through a valid/ready handshake.

## Interface
- `WL`, 8, data word width in bits.
- `BAUD_RATE`, 9600, serial bit rate in bits/s.
- `CLK_FREQ`, 100000000, `CLK` frequency in Hz. Bit period `BIT_CYCLES = CLK_FREQ/BAUD_RATE`, integer division, truncated. Requirement: `BIT_CYCLES >= 2`.
- `CLK`, input, 1, system clock, rising edge.
- `RST`, input, 1, reset. One clock; reset is synchronous and active-high.
- `tx_valid`, input, 1, `din` holds a word to send.
- `din`, input, WL, word to transmit.
- `tx_ready`, output, 1, transmitter idle and able to accept a word.
- `uart_tx`, output, 1, serial line output. Idles high.
- `tx_done`, output, 1, one-cycle pulse at the end of each frame's stop bit.

## Operation
- Reset values: `uart_tx` = 1, `tx_ready` = 1, `tx_done` = 0. The state machine goes to IDLE and all counters clear.
- **Acceptance:** a word is accepted on a rising edge where `tx_valid && tx_ready`. `din` is latched into a shift register, and the even-parity bit `^din` is latched at the same time. Later changes to `din` have no effect on the frame in flight.
- While `tx_ready` = 0, `tx_valid` is ignored. No queueing.
- **States:**
  - IDLE: `uart_tx` = 1, `tx_ready` = 1. On acceptance, go to START.
  - START: `uart_tx` = 0 for BIT_CYCLES cycles, then go to DATA.
  - DATA: `uart_tx` = shift register bit 0, shifted right once per bit period. Data bit k (LSB = bit 0) is driven for BIT_CYCLES cycles. After the WL-th bit, go to PARITY.
  - PARITY: `uart_tx` = latched parity bit for BIT_CYCLES cycles, then go to STOP.
  - STOP: `uart_tx` = 1 for BIT_CYCLES cycles, then go to IDLE.
- **Parity:** even parity. The total count of 1s across data bits plus the parity bit is even. This matches the receiver's `check_parity = ^data` comparison.
- **Counters:**
  - Baud counter width `$clog2(BIT_CYCLES)`. Counts 0..BIT_CYCLES-1, then wraps to 0 on each bit boundary.
  - Bit counter width `$clog2(WL+1)`. Counts data bits 0..WL-1 and is cleared on leaving DATA.
- **`tx_done`:** asserted for exactly one cycle, on the cycle after the last STOP cycle, which is the same cycle IDLE is entered. It is never asserted otherwise.
- **Reset mid-frame:** on the next rising edge all outputs take their reset values (`uart_tx` = 1 immediately, even mid-bit), the state becomes IDLE, and no `tx_done` is produced.
- **`uart_tx` is registered:** it is driven from a flop and never combinationally from `din` or `tx_valid`.

## Timing
- **Acceptance edge (cycle 0):** `tx_ready` falls and `uart_tx` falls (start bit) after this edge, both visible in cycle 1.
- **Frame length:** exactly `(WL+3)*BIT_CYCLES` cycles of non-idle line, from the first start-bit cycle to the last stop-bit cycle inclusive.
- **Bit boundaries:** bit n of the frame (n=0 start, n=1..WL data, n=WL+1 parity, n=WL+2 stop) occupies cycles `1+n*BIT_CYCLES` through `(n+1)*BIT_CYCLES`.
- **End of frame:** `tx_done` = 1 and `tx_ready` = 1 in cycle `(WL+3)*BIT_CYCLES+1`.
- **Back-to-back:** if `tx_valid` is high in that cycle, the word is accepted there. The next start bit begins the following cycle, giving exactly one idle-high cycle between the stop bit and the next start bit in addition to the full stop period.
- **Throughput:** one word per `(WL+3)*BIT_CYCLES+1` cycles.

## Test plan
Use `WL`=8, `CLK_FREQ`=16, `BAUD_RATE`=1 (BIT_CYCLES=16, frame 176 cycles) unless stated.
- **Single word 0xA5:** send 0xA5 → line shows 0, then 1,0,1,0,0,1,0,1, then parity 0, then 1. Each level lasts 16 cycles. `tx_done` pulses once at cycle 177 and `tx_ready` returns high the same cycle.
- **Odd-weight word 0x07:** send 0x07 → data 1,1,1,0,0,0,0,0 and parity bit 1. Sending 0x00 → parity 0. Sending 0xFF → parity 0.
- **Back-to-back 0x3C then 0xC3:** hold `tx_valid` high → the second start bit falls exactly 1 cycle after the first frame's `tx_done`. Both frames are bit-exact. Two `tx_done` pulses, spaced 177 cycles apart.
- **Busy ignore:** during the 0x55 frame, toggle `din` and pulse `tx_valid` at cycle 40 → the frame is unchanged (0x55, parity 0). No second frame is sent and `tx_ready` stays 0 until cycle 177.
- **Reset mid-frame:** assert `RST` for 1 cycle at cycle 90 of a 0x00 frame (line low) → `uart_tx` = 1, `tx_ready` = 1, `tx_done` = 0 on the following cycle, with no `tx_done` afterwards. A new word 0x81 sent 5 cycles later transmits correctly.
- **Default parameters:** with defaults (BIT_CYCLES=10416), send 0x5A → each bit lasts exactly 10416 cycles and the frame lasts 114576 cycles.
